// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, drives imem_addr and
// presents a registered instruction to the processor.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        synchronous, active-high reset
//   next         processor done strobe, retires the current instr
//   jump_en      with next, load PC from jump_addr instead of PC+1
//   jump_addr    jump target
//   imem_addr    instruction memory address (the PC register)
//   imem_data    combinational read data from instruction memory
//   instr        registered instruction for the processor
//   instr_valid  instr holds a live instruction awaiting next
//   halted       halt word fetched, fetch stopped until reset
//   retire_count (IFETCH_RETIRE_CNT_EN only) saturating count of
//                accepted next strobes
//
// Optional feature macro: IFETCH_RETIRE_CNT_EN
module instr_fetch_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned INSTR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               next,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
`ifdef IFETCH_RETIRE_CNT_EN
  output logic [15:0]        retire_count,
`endif
  output logic               halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic               valid_nxt;
  logic               halted_nxt;
  logic               retire;

  assign imem_addr = pc;

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_ADDR;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_valid <= valid_nxt;
      halted      <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: begin
        if (imem_data == HALT_WORD) state_nxt = HALTED;
        else                        state_nxt = EXEC;
      end
      EXEC: begin
        if (next) state_nxt = FETCH;
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = FETCH;
    endcase
  end

  // Next values of the registered outputs; HALTED holds everything.
  always_comb begin
    pc_nxt     = pc;
    instr_nxt  = instr;
    valid_nxt  = instr_valid;
    halted_nxt = halted;
    retire     = 1'b0;
    unique case (state)
      FETCH: begin
        if (imem_data == HALT_WORD) begin
          halted_nxt = 1'b1;
          valid_nxt  = 1'b0;
        end else begin
          instr_nxt = imem_data;
          valid_nxt = 1'b1;
        end
      end
      EXEC: begin
        if (next) begin
          retire    = 1'b1;
          valid_nxt = 1'b0;
          pc_nxt    = jump_en ? jump_addr
                              : pc + ADDR_W'(1);
        end
      end
      HALTED: begin
        halted_nxt = 1'b1;
      end
      default: begin
        valid_nxt = 1'b0;
      end
    endcase
  end

`ifdef IFETCH_RETIRE_CNT_EN
  logic [15:0] retire_q;

  always_ff @(posedge clk) begin
    if (reset)
      retire_q <= '0;
    else if (retire && retire_q != 16'hFFFF)
      retire_q <= retire_q + 16'd1;
  end

  assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an expected-output queue.
// Inputs change 1ns after a rising edge; outputs checked there too.
module tb_instr_fetch_unit;

  typedef struct {
    string       tag;
    logic [7:0]  addr;
    logic [15:0] instr;
    logic        valid;
    logic        halted;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        next = 1'b0;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_addr = '0;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        halted;
`ifdef IFETCH_RETIRE_CNT_EN
  logic [15:0] retire_count;
`endif

  logic [15:0] mem [256];
  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  instr_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .next         (next),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instr        (instr),
    .instr_valid  (instr_valid),
`ifdef IFETCH_RETIRE_CNT_EN
    .retire_count (retire_count),
`endif
    .halted       (halted)
  );

  task automatic push(input string tag, input logic [7:0] a,
                      input logic [15:0] i, input logic v,
                      input logic h);
    exp_t e;
    e.tag = tag;
    e.addr = a;
    e.instr = i;
    e.valid = v;
    e.halted = h;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty got %0d want 1", sb.size());
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (imem_addr === e.addr) else begin
      errors++;
      $error("FAIL %s.addr got %h want %h", e.tag, imem_addr, e.addr);
    end
    checks++;
    assert (instr === e.instr) else begin
      errors++;
      $error("FAIL %s.instr got %h want %h", e.tag, instr, e.instr);
    end
    checks++;
    assert (instr_valid === e.valid) else begin
      errors++;
      $error("FAIL %s.valid got %b want %b", e.tag, instr_valid, e.valid);
    end
    checks++;
    assert (halted === e.halted) else begin
      errors++;
      $error("FAIL %s.halted got %b want %b", e.tag, halted, e.halted);
    end
  endtask

  // Push the expectation, cross one rising edge, then compare.
  task automatic step(input string tag, input logic [7:0] a,
                      input logic [15:0] i, input logic v,
                      input logic h);
    push(tag, a, i, v, h);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
    #1;

    // Reset sequence
    mem[0] = 16'h1234;
    reset = 1'b1;
    step("rst0", 8'h00, 16'h0000, 1'b0, 1'b0);
    step("rst1", 8'h00, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    step("first", 8'h00, 16'h1234, 1'b1, 1'b0);
    step("hold", 8'h00, 16'h1234, 1'b1, 1'b0);

    // Sequential advance into halt
    mem[0] = 16'h0101;
    mem[1] = 16'h0202;
    mem[2] = 16'h0303;
    mem[3] = 16'hFFFF;
    reset = 1'b1;
    step("rst2", 8'h00, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    step("seq0", 8'h00, 16'h0101, 1'b1, 1'b0);
    next = 1'b1;
    step("nx0", 8'h01, 16'h0101, 1'b0, 1'b0);
    next = 1'b0;
    step("seq1", 8'h01, 16'h0202, 1'b1, 1'b0);
    next = 1'b1;
    step("nx1", 8'h02, 16'h0202, 1'b0, 1'b0);
    next = 1'b0;
    step("seq2", 8'h02, 16'h0303, 1'b1, 1'b0);
    next = 1'b1;
    step("nx2", 8'h03, 16'h0303, 1'b0, 1'b0);
    next = 1'b0;
    step("halt", 8'h03, 16'h0303, 1'b0, 1'b1);
    next = 1'b1;
    jump_en = 1'b1;
    jump_addr = 8'h10;
    step("hnx0", 8'h03, 16'h0303, 1'b0, 1'b1);
    step("hnx1", 8'h03, 16'h0303, 1'b0, 1'b1);
    next = 1'b0;
    jump_en = 1'b0;
    reset = 1'b1;
    step("hrst", 8'h00, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;

    // Ignored inputs in FETCH, jump_en alone in EXEC
    next = 1'b1;
    jump_en = 1'b1;
    jump_addr = 8'h40;
    step("fign", 8'h00, 16'h0101, 1'b1, 1'b0);
    next = 1'b0;
    step("jign", 8'h00, 16'h0101, 1'b1, 1'b0);
    jump_en = 1'b0;
    next = 1'b1;
    reset = 1'b1;
    step("abort", 8'h00, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    next = 1'b0;

    // Jump to the top address, then wrap
    mem[8'hFF] = 16'hABCD;
    step("j0", 8'h00, 16'h0101, 1'b1, 1'b0);
    next = 1'b1;
    jump_en = 1'b1;
    jump_addr = 8'hFF;
    step("jmp", 8'hFF, 16'h0101, 1'b0, 1'b0);
    next = 1'b0;
    jump_en = 1'b0;
    step("jf", 8'hFF, 16'hABCD, 1'b1, 1'b0);
    next = 1'b1;
    step("wrap", 8'h00, 16'hABCD, 1'b0, 1'b0);
    next = 1'b0;
    step("wf", 8'h00, 16'h0101, 1'b1, 1'b0);

    // next held high: one instruction per two cycles
    next = 1'b1;
    step("c0", 8'h01, 16'h0101, 1'b0, 1'b0);
    step("c1", 8'h01, 16'h0202, 1'b1, 1'b0);
    step("c2", 8'h02, 16'h0202, 1'b0, 1'b0);
    step("c3", 8'h02, 16'h0303, 1'b1, 1'b0);
    step("c4", 8'h03, 16'h0303, 1'b0, 1'b0);
    next = 1'b0;
    step("c5", 8'h03, 16'h0303, 1'b0, 1'b1);

`ifdef IFETCH_RETIRE_CNT_EN
    checks++;
    assert (retire_count === 16'd5) else begin
      errors++;
      $error("FAIL rcnt got %0d want 5", retire_count);
    end
    reset = 1'b1;
    step("r3", 8'h00, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    checks++;
    assert (retire_count === 16'd0) else begin
      errors++;
      $error("FAIL rcnt_rst got %0d want 0", retire_count);
    end
    step("s0", 8'h00, 16'h0101, 1'b1, 1'b0);
    force dut.retire_q = 16'hFFFF;
    #1;
    release dut.retire_q;
    next = 1'b1;
    step("s1", 8'h01, 16'h0101, 1'b0, 1'b0);
    next = 1'b0;
    checks++;
    assert (retire_count === 16'hFFFF) else begin
      errors++;
      $error("FAIL rcnt_sat got %h want ffff", retire_count);
    end
`endif

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_left got %0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
